// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and constants for the FC output stage
package fc_pkg;

  // Controller states for the sequential argmax
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } argmax_state_t;

  // Default score width (two's-complement signed fixed point)
  localparam int DATA_W_DEF = 16;

  // Width of the class index presented on class_out
  localparam int IDX_W = 16;

endpackage

// File: rtl/score_compare.sv
// rtl/score_compare.sv - signed strict greater-than of two scores
module score_compare #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              gt_o
);

  // Strict compare so that equal scores never displace the earlier index
  assign gt_o = $signed(a_i) > $signed(b_i);

endmodule

// File: rtl/argmax_scheduler.sv
// rtl/argmax_scheduler.sv - sequential argmax over a stream of class scores (option: ARGMAX_SCORE_OUT_EN)
module argmax_scheduler
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  class_out,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [DATA_W-1:0] score_out,
`endif
  output logic              err,
  output logic              busy
);

  argmax_state_t     state_q;
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  count_d;
  logic [IDX_W-1:0]  best_idx_q;
  logic [DATA_W-1:0] best_val_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              err_q;

  logic              gt;
  logic              take_new;
  logic              cnt_end;
  logic              term;

  // The single shared comparator: incoming score against the running best
  score_compare #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .a_i (in_data),
    .b_i (best_val_q),
    .gt_o(gt)
  );

  // Beat bookkeeping: first beat always loads, later beats load only on a strict win
  always_comb begin
    count_d  = count_q + IDX_W'(1);
    cnt_end  = (count_q == IDX_W'(NUM_CLASSES - 1));
    term     = in_last || cnt_end;
    take_new = (count_q == '0) || gt;
  end

  // Controller FSM with registered handshake, status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            count_q    <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            count_q <= count_d;
            if (take_new) begin
              best_val_q <= in_data;
              best_idx_q <= count_q;
            end
            if (term) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              // Length mismatch: producer's marker and our count disagree
              err_q       <= in_last ^ cnt_end;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign class_out = best_idx_q;
`ifdef ARGMAX_SCORE_OUT_EN
  assign score_out = best_val_q;
`endif

endmodule

// File: tb/tb_argmax_scheduler.sv
// tb/tb_argmax_scheduler.sv - self-checking bench for argmax_scheduler
module tb_argmax_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] class_out;
  logic        err;
  logic        busy;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [15:0] score_out;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [9:0][15:0] sc;
    int               nb;
    int               last_pos;
    int               exp_cls;
    bit               exp_err;
  } vec_t;

  typedef struct {
    int          cls;
    bit          err;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[5];

  argmax_scheduler #(.NUM_CLASSES(10), .DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .class_out(class_out),
`ifdef ARGMAX_SCORE_OUT_EN
    .score_out(score_out),
`endif
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_argmax(input logic [9:0][15:0] sc, input int nb,
                                     output int cls, output logic [15:0] val);
    cls = 0;
    val = sc[0];
    for (int i = 1; i < nb; i++) begin
      if ($signed(sc[i]) > $signed(val)) begin
        cls = i;
        val = sc[i];
      end
    end
  endfunction

  // Entered and left at #1 after a rising edge
  task automatic run_vector(input vec_t v, input bit gaps, input int hold);
    exp_t e;
    exp_t r;
    int   cls;
    logic [15:0] val;
    ref_argmax(v.sc, v.nb, cls, val);
    e.cls = v.exp_cls;
    e.err = v.exp_err;
    e.val = val;
    // start with a simultaneous beat that must not be taken
    start = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF; in_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("in_ready_after_start", in_ready, 1);
    chk("err_cleared_on_start", err, 0);
    chk("class_cleared_on_start", class_out, 0);
    for (int b = 0; b < v.nb; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v.sc[b];
      in_last  = (b == v.last_pos);
      if (b == v.nb - 1) sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("out_valid_latency", out_valid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    r = sb.pop_front();
    chk("class_out", class_out, r.cls);
    chk("err", err, r.err);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("score_out", score_out, r.val);
`endif
    // consumer stalls; stray start and beats must be ignored
    in_valid = 1'b1; in_data = 16'h7FFF; start = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_class_stable", class_out, r.cls);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_accept", out_valid, 0);
    chk("busy_after_accept", busy, 0);
    chk("err_sticky_in_idle", err, r.err);
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    int s0[10] = '{0, 5, 3, -2, 7, 7, 1, 0, 6, 2};
    vec_t rv;
    int   cls;
    logic [15:0] val;

    tbl[0].nb = 10; tbl[0].last_pos = 9;  tbl[0].exp_cls = 4; tbl[0].exp_err = 0;
    for (int i = 0; i < 10; i++) tbl[0].sc[i] = 16'(s0[i]);
    tbl[1].nb = 10; tbl[1].last_pos = 9;  tbl[1].exp_cls = 0; tbl[1].exp_err = 0;
    for (int i = 0; i < 10; i++) tbl[1].sc[i] = 16'h8000;
    tbl[2] = tbl[1];
    tbl[2].sc[0] = 16'hFFFF; tbl[2].sc[3] = 16'h0001; tbl[2].exp_cls = 3;
    tbl[3] = tbl[0];
    tbl[3].nb = 7; tbl[3].last_pos = 6; tbl[3].exp_cls = 4; tbl[3].exp_err = 1;
    tbl[4] = tbl[0];
    tbl[4].last_pos = -1; tbl[4].exp_cls = 4; tbl[4].exp_err = 1;

    start = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) run_vector(tbl[t], 1'b0, 2);

    // gapped stream with a five-cycle stalled consumer
    run_vector(tbl[0], 1'b1, 5);

    // reset mid-vector after beat 4
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1; in_data = (b == 2) ? 16'h7FFF : 16'(b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_class_out", class_out, 0);
    chk("midrst_err", err, 0);
    chk("midrst_busy", busy, 0);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("midrst_score_out", score_out, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_vector(tbl[0], 1'b0, 1);

    // random vectors, expected values from the reference model
    for (int k = 0; k < 6; k++) begin
      rv.nb = $urandom_range(2, 10);
      for (int i = 0; i < 10; i++) rv.sc[i] = 16'($urandom_range(0, 65535));
      if (k % 2 == 0) rv.sc[$urandom_range(0, rv.nb - 1)] = rv.sc[0];
      if (rv.nb < 10) begin
        rv.last_pos = rv.nb - 1; rv.exp_err = 1;
      end else if (k % 3 == 0) begin
        rv.last_pos = -1; rv.exp_err = 1;
      end else begin
        rv.last_pos = 9; rv.exp_err = 0;
      end
      ref_argmax(rv.sc, rv.nb, cls, val);
      rv.exp_cls = cls;
      run_vector(rv, 1'b1, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
